// File: rtl/gelato_fetch_scheduler.sv
// gelato_fetch_scheduler
//   Round-robin instruction fetch scheduler. Each cycle in IDLE it picks the
//   next warp whose split table presents a valid PC and that has no fetch in
//   flight, issues one icache request, and on the icache response forwards the
//   instruction to decode. It also writes pc+4 back to the warp's split-table
//   entry, stalling that entry when the instruction is a control transfer.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   rdy                   global enable, 0 freezes all state
//   sel_valid/pc/tbl      per-warp candidate PC from the split tables (flat)
//   req_valid/ready/pc/warp   icache request channel
//   rsp_valid/ready/warp/inst icache response channel
//   upd_valid/tbl/pc/stall    one-hot split-table write-back strobe
//   inst_valid/ready/inst/inst_pc/inst_warp/inst_tbl  decode channel
//   err                   sticky: response arrived for a warp with no fetch

// Per-warp slot: outstanding-fetch flag plus the PC/table index captured at grant.
module gelato_fetch_warp_slot #(
    parameter int PC_WIDTH = 32,
    parameter int TBL_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                load_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [TBL_W-1:0]    tbl_i,
    input  logic                set_busy_i,
    input  logic                clr_busy_i,
    output logic                busy_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [TBL_W-1:0]    tbl_o
);
    logic                busy_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [TBL_W-1:0]    tbl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            pc_q   <= '0;
            tbl_q  <= '0;
        end else if (en_i) begin
            if (load_i) begin
                pc_q  <= pc_i;
                tbl_q <= tbl_i;
            end
            // A handshake and a response can never legitimately target the
            // same warp in one cycle; set wins if it ever happens.
            if (set_busy_i)      busy_q <= 1'b1;
            else if (clr_busy_i) busy_q <= 1'b0;
        end
    end

    assign busy_o = busy_q;
    assign pc_o   = pc_q;
    assign tbl_o  = tbl_q;
endmodule

module gelato_fetch_scheduler #(
    parameter int WARP_NUM = 4,
    parameter int PC_WIDTH = 32,
    parameter int TBL_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic [WARP_NUM-1:0]          sel_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0] sel_pc,
    input  logic [WARP_NUM*TBL_W-1:0]    sel_tbl,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [PC_WIDTH-1:0]          req_pc,
    output logic [$clog2(WARP_NUM)-1:0]  req_warp,
    input  logic                         rsp_valid,
    output logic                         rsp_ready,
    input  logic [$clog2(WARP_NUM)-1:0]  rsp_warp,
    input  logic [31:0]                  rsp_inst,
    output logic [WARP_NUM-1:0]          upd_valid,
    output logic [TBL_W-1:0]             upd_tbl,
    output logic [PC_WIDTH-1:0]          upd_pc,
    output logic                         upd_stall,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [31:0]                  inst,
    output logic [PC_WIDTH-1:0]          inst_pc,
    output logic [$clog2(WARP_NUM)-1:0]  inst_warp,
    output logic [TBL_W-1:0]             inst_tbl,
    output logic                         err
);
    localparam int WW = $clog2(WARP_NUM);
    localparam logic [WW:0] WARP_CNT = WARP_NUM[WW:0];
    localparam logic [WW-1:0] LAST_WARP = WW'(WARP_NUM - 1);

    typedef enum logic {IDLE, REQ} state_e;

    state_e              state_q, state_d;
    logic [WW-1:0]       last_grant_q, last_grant_d;
    logic                req_valid_q, req_valid_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [WW-1:0]       req_warp_q, req_warp_d;
    logic [WARP_NUM-1:0] upd_valid_q, upd_valid_d;
    logic [TBL_W-1:0]    upd_tbl_q, upd_tbl_d;
    logic [PC_WIDTH-1:0] upd_pc_q, upd_pc_d;
    logic                upd_stall_q, upd_stall_d;
    logic                inst_valid_q, inst_valid_d;
    logic [31:0]         inst_q, inst_d;
    logic [PC_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [WW-1:0]       inst_warp_q, inst_warp_d;
    logic [TBL_W-1:0]    inst_tbl_q, inst_tbl_d;
    logic                err_q, err_d;

    logic [WARP_NUM-1:0] busy, eligible, grant_ld, set_busy, clr_busy;
    logic [PC_WIDTH-1:0] sel_pc_w   [WARP_NUM];
    logic [TBL_W-1:0]    sel_tbl_w  [WARP_NUM];
    logic [PC_WIDTH-1:0] saved_pc   [WARP_NUM];
    logic [TBL_W-1:0]    saved_tbl  [WARP_NUM];

    logic          grant_found;
    logic [WW-1:0] grant_idx, cand_idx;
    logic          rsp_fire, rsp_hit, is_ctrl;

    genvar g;
    generate
        for (g = 0; g < WARP_NUM; g++) begin : g_warp
            assign sel_pc_w[g]  = sel_pc[g*PC_WIDTH +: PC_WIDTH];
            assign sel_tbl_w[g] = sel_tbl[g*TBL_W +: TBL_W];

            gelato_fetch_warp_slot #(
                .PC_WIDTH (PC_WIDTH),
                .TBL_W    (TBL_W)
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .en_i       (rdy),
                .load_i     (grant_ld[g]),
                .pc_i       (sel_pc_w[g]),
                .tbl_i      (sel_tbl_w[g]),
                .set_busy_i (set_busy[g]),
                .clr_busy_i (clr_busy[g]),
                .busy_o     (busy[g]),
                .pc_o       (saved_pc[g]),
                .tbl_o      (saved_tbl[g])
            );
        end
    endgenerate

    // Eligibility uses the registered busy bits, so a warp released by a
    // response this cycle only competes from the next cycle on.
    assign eligible = sel_valid & ~busy;

    // Round-robin: first eligible index strictly after last_grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 1; i <= WARP_NUM; i++) begin
            cand_idx = WW'((int'(last_grant_q) + i) % WARP_NUM);
            if (!grant_found && eligible[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign rsp_ready = rdy && (!inst_valid_q || inst_ready);
    assign rsp_fire  = rsp_valid && rsp_ready;
    // Responses naming a warp index beyond WARP_NUM count as stray.
    assign rsp_hit   = ({1'b0, rsp_warp} < WARP_CNT) && busy[rsp_warp];
    // Branch, JAL and JALR leave the next PC unknown until resolution.
    assign is_ctrl   = (rsp_inst[6:0] == 7'b1100011) ||
                       (rsp_inst[6:0] == 7'b1101111) ||
                       (rsp_inst[6:0] == 7'b1100111);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_valid_d  = req_valid_q;
        req_pc_d     = req_pc_q;
        req_warp_d   = req_warp_q;
        upd_valid_d  = upd_valid_q;
        upd_tbl_d    = upd_tbl_q;
        upd_pc_d     = upd_pc_q;
        upd_stall_d  = upd_stall_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_warp_d  = inst_warp_q;
        inst_tbl_d   = inst_tbl_q;
        err_d        = err_q;
        grant_ld     = '0;
        set_busy     = '0;
        clr_busy     = '0;

        if (rdy) begin
            // The strobe only retires on an enabled cycle, so a pulse that
            // lands while rdy is low is presented once rdy returns.
            upd_valid_d = '0;

            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        grant_ld[grant_idx] = 1'b1;
                        req_valid_d = 1'b1;
                        req_pc_d    = sel_pc_w[grant_idx];
                        req_warp_d  = grant_idx;
                        state_d     = REQ;
                    end
                end
                REQ: begin
                    if (req_valid_q && req_ready) begin
                        set_busy[req_warp_q] = 1'b1;
                        last_grant_d = req_warp_q;
                        req_valid_d  = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (inst_valid_q && inst_ready) inst_valid_d = 1'b0;

            if (rsp_fire) begin
                if (rsp_hit) begin
                    clr_busy[rsp_warp]    = 1'b1;
                    upd_valid_d[rsp_warp] = 1'b1;
                    upd_tbl_d    = saved_tbl[rsp_warp];
                    upd_pc_d     = saved_pc[rsp_warp] + PC_WIDTH'(4);
                    upd_stall_d  = is_ctrl;
                    inst_valid_d = 1'b1;
                    inst_d       = rsp_inst;
                    inst_pc_d    = saved_pc[rsp_warp];
                    inst_warp_d  = rsp_warp;
                    inst_tbl_d   = saved_tbl[rsp_warp];
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_WARP;
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            req_warp_q   <= '0;
            upd_valid_q  <= '0;
            upd_tbl_q    <= '0;
            upd_pc_q     <= '0;
            upd_stall_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_warp_q  <= '0;
            inst_tbl_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            req_warp_q   <= req_warp_d;
            upd_valid_q  <= upd_valid_d;
            upd_tbl_q    <= upd_tbl_d;
            upd_pc_q     <= upd_pc_d;
            upd_stall_q  <= upd_stall_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_warp_q  <= inst_warp_d;
            inst_tbl_q   <= inst_tbl_d;
            err_q        <= err_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_pc     = req_pc_q;
    assign req_warp   = req_warp_q;
    assign upd_valid  = rdy ? upd_valid_q : '0;
    assign upd_tbl    = upd_tbl_q;
    assign upd_pc     = upd_pc_q;
    assign upd_stall  = upd_stall_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_warp  = inst_warp_q;
    assign inst_tbl   = inst_tbl_q;
    assign err        = err_q;
endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Directed bench for gelato_fetch_scheduler (4 warps, 32-bit PC, 2-bit table).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_gelato_fetch_scheduler;
    logic         clk = 1'b0;
    logic         rst, rdy;
    logic [3:0]   sel_valid;
    logic [127:0] sel_pc;
    logic [7:0]   sel_tbl;
    logic         req_valid, req_ready;
    logic [31:0]  req_pc;
    logic [1:0]   req_warp;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_warp;
    logic [31:0]  rsp_inst;
    logic [3:0]   upd_valid;
    logic [1:0]   upd_tbl;
    logic [31:0]  upd_pc;
    logic         upd_stall;
    logic         inst_valid, inst_ready;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic [1:0]   inst_warp;
    logic [1:0]   inst_tbl;
    logic         err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_pc [4];

    gelato_fetch_scheduler #(.WARP_NUM(4), .PC_WIDTH(32), .TBL_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .sel_valid  (sel_valid),
        .sel_pc     (sel_pc),
        .sel_tbl    (sel_tbl),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .req_warp   (req_warp),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_warp   (rsp_warp),
        .rsp_inst   (rsp_inst),
        .upd_valid  (upd_valid),
        .upd_tbl    (upd_tbl),
        .upd_pc     (upd_pc),
        .upd_stall  (upd_stall),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_warp  (inst_warp),
        .inst_tbl   (inst_tbl),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_pc[0] = 32'h0000_1000;
        exp_pc[1] = 32'h0000_2000;
        exp_pc[2] = 32'h0000_0100;
        exp_pc[3] = 32'hFFFF_FFFC;
        rst = 1'b1; rdy = 1'b1; sel_valid = 4'h0;
        sel_pc  = {exp_pc[3], exp_pc[2], exp_pc[1], exp_pc[0]};
        sel_tbl = {2'd3, 2'd1, 2'd2, 2'd0};
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_warp = 2'd0; rsp_inst = 32'h0;
        inst_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_pc", req_pc, 0);
        chk("rst_req_warp", req_warp, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_upd_pc", upd_pc, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_err", err, 0);

        // Round-robin 0,1,2,3,0 at one request per two cycles; warp 0 is
        // answered early so it is free again for the fifth grant.
        rst = 1'b0; sel_valid = 4'hF; req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            rsp_valid = 1'b0;
            chk("rr_req_valid", req_valid, 1);
            chk("rr_req_warp", req_warp, k % 4);
            chk("rr_req_pc", req_pc, exp_pc[k % 4]);
            step();
            chk("rr_hs_clear", req_valid, 0);
            if (k == 0) begin
                rsp_valid = 1'b1; rsp_warp = 2'd0; rsp_inst = 32'h0000_0013;
            end
        end

        // Warp 2 response, plain ADDI
        rsp_valid = 1'b1; rsp_warp = 2'd2; rsp_inst = 32'h0000_0013;
        step();
        rsp_valid = 1'b0;
        chk("w2_upd_valid", upd_valid, 4'b0100);
        chk("w2_upd_pc", upd_pc, 32'h104);
        chk("w2_upd_tbl", upd_tbl, 1);
        chk("w2_upd_stall", upd_stall, 0);
        chk("w2_inst_valid", inst_valid, 1);
        chk("w2_inst", inst, 32'h13);
        chk("w2_inst_pc", inst_pc, 32'h100);
        chk("w2_inst_warp", inst_warp, 2);
        chk("w2_inst_tbl", inst_tbl, 1);
        chk("w2_no_same_cycle_grant", req_valid, 0);
        step();
        chk("w2_upd_one_cycle", upd_valid, 0);
        chk("w2_inst_consumed", inst_valid, 0);
        chk("w2_regrant_valid", req_valid, 1);
        chk("w2_regrant_warp", req_warp, 2);

        // req_ready low for 5 cycles; sel_pc changes must not leak in
        req_ready = 1'b0;
        sel_pc[95:64] = 32'h0000_0500;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_req_valid", req_valid, 1);
            chk("hold_req_pc", req_pc, 32'h100);
            chk("hold_req_warp", req_warp, 2);
        end
        req_ready = 1'b1;
        step();
        chk("hold_hs_clear", req_valid, 0);

        // JAL at the top of the address space: wrap and stall
        rsp_valid = 1'b1; rsp_warp = 2'd3; rsp_inst = 32'h0000_006F;
        step();
        chk("jal_upd_valid", upd_valid, 4'b1000);
        chk("jal_upd_pc", upd_pc, 32'h0);
        chk("jal_upd_stall", upd_stall, 1);
        chk("jal_upd_tbl", upd_tbl, 3);
        chk("jal_inst_pc", inst_pc, 32'hFFFF_FFFC);

        // Decode back-pressure: second response must wait, no loss
        inst_ready = 1'b0;
        rsp_valid = 1'b1; rsp_warp = 2'd0; rsp_inst = 32'h00A0_0093;
        #1;
        chk("bp_rsp_ready_low", rsp_ready, 0);
        step();
        chk("bp_inst_held", inst, 32'h6F);
        chk("bp_inst_valid", inst_valid, 1);
        chk("bp_no_upd", upd_valid, 0);
        chk("bp_w3_regrant", req_warp, 3);
        step();
        chk("bp_inst_held2", inst, 32'h6F);
        inst_ready = 1'b1; sel_valid = 4'h0;
        #1;
        chk("bp_rsp_ready_high", rsp_ready, 1);
        step();
        chk("bp_inst_valid2", inst_valid, 1);
        chk("bp_inst2", inst, 32'h00A0_0093);
        chk("bp_inst_warp2", inst_warp, 0);
        chk("bp_inst_pc2", inst_pc, 32'h1000);
        chk("bp_upd_valid2", upd_valid, 4'b0001);
        chk("bp_upd_pc2", upd_pc, 32'h1004);
        chk("bp_upd_stall2", upd_stall, 0);

        // BEQ on warp 1
        rsp_warp = 2'd1; rsp_inst = 32'h0000_0063;
        step();
        rsp_valid = 1'b0;
        chk("beq_upd_valid", upd_valid, 4'b0010);
        chk("beq_upd_stall", upd_stall, 1);
        chk("beq_upd_pc", upd_pc, 32'h2004);
        chk("beq_upd_tbl", upd_tbl, 2);
        step();
        chk("beq_inst_consumed", inst_valid, 0);

        // Stray response for idle warp 1
        rsp_valid = 1'b1; rsp_warp = 2'd1; rsp_inst = 32'h0000_0013;
        step();
        rsp_valid = 1'b0;
        chk("stray_err", err, 1);
        chk("stray_no_upd", upd_valid, 0);
        chk("stray_no_inst", inst_valid, 0);
        step(); step();
        chk("stray_err_sticky", err, 1);

        // rdy=0 freezes everything
        rdy = 1'b0; rsp_valid = 1'b1; rsp_warp = 2'd3; rsp_inst = 32'h0000_0067;
        #1;
        chk("frz_rsp_ready", rsp_ready, 0);
        step();
        chk("frz_no_inst", inst_valid, 0);
        chk("frz_no_upd", upd_valid, 0);
        chk("frz_no_req", req_valid, 0);
        rdy = 1'b1;
        step();
        rsp_valid = 1'b0;
        chk("jalr_upd_valid", upd_valid, 4'b1000);
        chk("jalr_upd_pc", upd_pc, 32'h0);
        chk("jalr_upd_stall", upd_stall, 1);
        chk("jalr_inst_tbl", inst_tbl, 3);
        rdy = 1'b0;
        #1;
        chk("frz_upd_masked", upd_valid, 0);
        step(); step();
        chk("frz_inst_held", inst_valid, 1);
        rdy = 1'b1;
        step();
        chk("thaw_inst_consumed", inst_valid, 0);

        // Asynchronous reset, then a late response
        rst = 1'b1;
        #1;
        chk("arst_err", err, 0);
        chk("arst_inst_valid", inst_valid, 0);
        rst = 1'b0;
        rsp_valid = 1'b1; rsp_warp = 2'd0; rsp_inst = 32'h0000_0013;
        step();
        rsp_valid = 1'b0;
        chk("late_rsp_err", err, 1);
        chk("late_rsp_no_inst", inst_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gelato_fetch_scheduler.md
GELATO_FETCH_SCHEDULER -- requirements
Module: gelato_fetch_scheduler

Interface
REQ-001 Parameters SHALL be:
- WARP_NUM, default 4: number of warps, at least 2.
- PC_WIDTH, default 32: PC width.
- TBL_W, default 2: split-table index width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; 0 freezes all state.
- sel_valid  in  WARP_NUM  per-warp selected PC is valid (from each warp's split table).
- sel_pc  in  WARP_NUM*PC_WIDTH  per-warp selected PC.
- sel_tbl  in  WARP_NUM*TBL_W  per-warp split-table index of sel_pc.
- req_valid  out  1  icache fetch request valid.
- req_ready  in  1  icache accepts request.
- req_pc  out  PC_WIDTH  fetch address.
- req_warp  out  clog2(WARP_NUM)  requesting warp.
- rsp_valid  in  1  icache response valid.
- rsp_ready  out  1  scheduler accepts response.
- rsp_warp  in  clog2(WARP_NUM)  responding warp.
- rsp_inst  in  32  fetched instruction.
- upd_valid  out  WARP_NUM  one-hot split-table update strobe.
- upd_tbl  out  TBL_W  split-table entry to update.
- upd_pc  out  PC_WIDTH  new PC for that entry.
- upd_stall  out  1  deactivate the entry until branch resolution.
- inst_valid  out  1  decoded-stage instruction valid.
- inst_ready  in  1  decode stage accepts.
- inst  out  32  instruction.
- inst_pc  out  PC_WIDTH  PC of inst.
- inst_warp  out  clog2(WARP_NUM)  warp of inst.
- inst_tbl  out  TBL_W  split-table index of inst.
- err  out  1  sticky protocol error.
REQ-003 Clock/reset SHALL be clk and rst; reset asynchronous, active-high.

Function
REQ-004 Per-warp state SHALL be busy bit, saved pc and saved tbl; at most one outstanding fetch per warp.
REQ-005 FSM states SHALL be IDLE and REQ.
- IDLE: eligible = sel_valid & ~busy (registered busy). If any eligible, grant the first eligible index strictly after last_grant, circularly, wrapping WARP_NUM-1 to 0. On grant: latch pc/tbl/warp, load req_*, set req_valid, go to REQ.
- REQ: hold req_pc and req_warp stable. When req_valid && req_ready: set busy[warp], last_grant<=warp, req_valid<=0, return to IDLE.
- Grant-to-req_valid latency 1 cycle; maximum issue rate 1 request per 2 cycles.
REQ-006 rsp_ready SHALL equal rdy && (!inst_valid || inst_ready).
REQ-007 On an accepted response to a busy warp w, the next cycle SHALL produce:
- inst_valid=1, inst=rsp_inst, inst_pc/inst_tbl from warp w's saved state, inst_warp=w.
- upd_valid = one-hot w for exactly 1 cycle, upd_tbl = saved tbl, upd_pc = saved pc+4 modulo 2^PC_WIDTH.
- upd_stall=1 iff rsp_inst[6:0] is 1100011, 1101111 or 1100111, else 0.
- busy[w] cleared.
REQ-008 inst_* SHALL hold until inst_valid && inst_ready, then inst_valid clears unless a new response is accepted in the same cycle.
REQ-009 A response for a non-busy warp SHALL be consumed and discarded: no upd or inst output, err<=1 (sticky until reset).
REQ-010 A response clearing busy[w] and an IDLE grant in the same cycle SHALL both proceed; w becomes eligible the following cycle.
REQ-011 With rdy=0: no state change, no grant, upd_valid=0, rsp_ready=0; req_valid and inst_valid holds, and a req handshake is not taken.
REQ-012 sel_* SHALL only be sampled at grant; later changes do not affect an issued request.

Reset
REQ-013 While rst=1 the block SHALL force:
- state=IDLE, busy=0, last_grant=WARP_NUM-1.
- req_valid=0, req_pc=0, req_warp=0.
- upd_valid=0, upd_tbl=0, upd_pc=0, upd_stall=0.
- inst_valid=0, inst=0, inst_pc=0, inst_warp=0, inst_tbl=0, err=0.
REQ-014 Reset mid-transaction SHALL drop all outstanding fetches; late responses after reset set err.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- Reset release, all sel_valid=1, req_ready=1 -> grants warp 0,1,2,3,0 in order, one per 2 cycles.
- Warp 2 sel_pc=0x100, tbl=1, response inst 0x00000013 -> upd_valid=4'b0100, upd_pc=0x104, upd_tbl=1, upd_stall=0; inst_pc=0x100.
- Response inst 0x0000006F (JAL) for a warp with pc=0xFFFFFFFC -> upd_pc=0x0, upd_stall=1.
- req_ready low 5 cycles -> req_pc/req_warp stable, busy unchanged until handshake.
- inst_ready=0 with inst_valid=1 -> rsp_ready=0, second response stalls, no data loss.
- rsp_warp=1 while busy[1]=0 -> no upd/inst output, err=1 persisting until rst.
